// File: rtl/wisc_mem_pkg.sv
// Shared types for the WISC memory stage.
// Holds the FSM encoding, write-back selects and the request holding bundle.
package wisc_mem_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam int TIMEOUT_DEF = 15;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic        rd;
    logic [1:0]  sel;
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] imm;
    logic        rw;
    logic [2:0]  wreg;
  } mem_hold_t;

  function automatic logic [15:0] wb_mux(
    input logic [1:0]  sel,
    input logic [15:0] mem,
    input logic [15:0] alu,
    input logic [15:0] pc,
    input logic [15:0] imm
  );
    logic [15:0] r;
    r = mem;
    unique case (sel)
      WB_MEM: r = mem;
      WB_ALU: r = alu;
      WB_PC:  r = pc;
      WB_IMM: r = imm;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dff_ar.sv
// Codebase D flip-flop cell, asynchronous active-high reset variant.
// Used for the M2W pipeline register.
module dff_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/mem_wait_ctr.sv
// 8-bit memory wait counter with clear, enable and terminal count.
// tc fires when the count equals TIMEOUT-1.
module mem_wait_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// WISC memory-stage controller: memory handshake, stall, WB select
// and the M2W pipeline register.
import wisc_mem_pkg::*;

module mem_stage_ctrl #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluOutM,
  input  logic [15:0] wrtDataM,
  input  logic        memWrtM,
  input  logic        readEnM,
  input  logic [1:0]  wbDataSelM,
  input  logic [15:0] aluFinalM,
  input  logic [15:0] addPCM,
  input  logic [15:0] imm8M,
  input  logic        regWrtM,
  input  logic [2:0]  wrtRegM,
  output logic [15:0] memAddr,
  output logic [15:0] memData,
  output logic        memRd,
  output logic        memWr,
  input  logic [15:0] memRdData,
  input  logic        memDone,
  output logic        stallM,
  output logic [15:0] wbDataW,
  output logic        regWrtW,
  output logic [2:0]  wrtRegW,
  output logic        errM
);

  mem_state_e  state_q, state_d;
  mem_hold_t   hold_q, hold_d, cur;
  logic        err_q, err_d;
  logic        req, tc, in_wait;
  logic [15:0] wb_d;
  logic        rw_d;
  logic [2:0]  wr_d;

  assign cur = '{addr: aluOutM, data: wrtDataM,
                 wr: memWrtM, rd: readEnM & ~memWrtM,
                 sel: wbDataSelM, alu: aluFinalM,
                 pc: addPCM, imm: imm8M,
                 rw: regWrtM, wreg: wrtRegM};

  assign req     = memWrtM | readEnM;
  assign in_wait = (state_q == S_WAIT);
  assign errM    = err_q;

  mem_wait_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (~in_wait),
    .en  (in_wait),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    wb_d    = wbDataW;
    rw_d    = 1'b0;
    wr_d    = wrtRegW;
    memAddr = cur.addr;
    memData = cur.data;
    memWr   = cur.wr;
    memRd   = cur.rd;
    stallM  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memWrtM && readEnM) err_d = 1'b1;
        if (!req || memDone) begin
          wb_d = wb_mux(cur.sel, memRdData,
                        cur.alu, cur.pc, cur.imm);
          rw_d = cur.rw;
          wr_d = cur.wreg;
        end else begin
          stallM  = 1'b1;
          hold_d  = cur;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        memAddr = hold_q.addr;
        memData = hold_q.data;
        memWr   = hold_q.wr;
        memRd   = hold_q.rd;
        if (memDone) begin
          wb_d = wb_mux(hold_q.sel, memRdData,
                        hold_q.alu, hold_q.pc, hold_q.imm);
          rw_d    = hold_q.rw;
          wr_d    = hold_q.wreg;
          state_d = S_IDLE;
        end else if (tc) begin
          // abandon the access; the slot leaves as a bubble
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stallM = 1'b1;
        end
      end
    endcase
    // reset must drop any request the same instant it asserts
    if (rst) begin
      memWr  = 1'b0;
      memRd  = 1'b0;
      stallM = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  dff_ar #(.W(16)) u_wb (.clk(clk), .rst(rst), .d(wb_d), .q(wbDataW));
  dff_ar #(.W(1))  u_rw (.clk(clk), .rst(rst), .d(rw_d), .q(regWrtW));
  dff_ar #(.W(3))  u_wr (.clk(clk), .rst(rst), .d(wr_d), .q(wrtRegW));

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl.
// Expected M2W results are queued at issue and popped at commit.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] aluOutM, wrtDataM, aluFinalM, addPCM, imm8M;
  logic        memWrtM, readEnM, regWrtM;
  logic [1:0]  wbDataSelM;
  logic [2:0]  wrtRegM;
  logic [15:0] memAddr, memData, memRdData;
  logic        memRd, memWr, memDone, stallM;
  logic [15:0] wbDataW;
  logic        regWrtW;
  logic [2:0]  wrtRegW;
  logic        errM;

  typedef struct packed {
    logic [15:0] wb;
    logic        rw;
    logic [2:0]  wr;
  } m2w_t;

  m2w_t sb_q[$];
  int errs;
  int checks;
  int n;

  mem_stage_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .aluOutM(aluOutM), .wrtDataM(wrtDataM),
    .memWrtM(memWrtM), .readEnM(readEnM),
    .wbDataSelM(wbDataSelM), .aluFinalM(aluFinalM),
    .addPCM(addPCM), .imm8M(imm8M),
    .regWrtM(regWrtM), .wrtRegM(wrtRegM),
    .memAddr(memAddr), .memData(memData),
    .memRd(memRd), .memWr(memWr),
    .memRdData(memRdData), .memDone(memDone),
    .stallM(stallM), .wbDataW(wbDataW),
    .regWrtW(regWrtW), .wrtRegW(wrtRegW),
    .errM(errM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    aluOutM = '0; wrtDataM = '0; memWrtM = 0; readEnM = 0;
    wbDataSelM = 2'b00; aluFinalM = '0; addPCM = '0; imm8M = '0;
    regWrtM = 0; wrtRegM = '0; memRdData = '0; memDone = 0;
  endtask

  task automatic push(input logic [15:0] wb, input logic rw,
                      input logic [2:0] wr);
    m2w_t e;
    e.wb = wb; e.rw = rw; e.wr = wr;
    sb_q.push_back(e);
  endtask

  task automatic sb_cmp(input string tag);
    m2w_t e;
    check({tag, ".avail"}, 32'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".wb"}, wbDataW, e.wb);
      check({tag, ".rw"}, regWrtW, e.rw);
      check({tag, ".wr"}, wrtRegW, e.wr);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".wb"}, wbDataW, 0);
    check({tag, ".rw"}, regWrtW, 0);
    check({tag, ".wr"}, wrtRegW, 0);
    check({tag, ".err"}, errM, 0);
    check({tag, ".rd"}, memRd, 0);
    check({tag, ".wrs"}, memWr, 0);
    check({tag, ".stall"}, stallM, 0);
  endtask

  initial begin
    errs = 0; checks = 0;
    idle_in();
    rst = 1;
    cyc(); cyc();
    chk_zero("por");

    // imm op, then asynchronous reset mid-cycle
    rst = 0;
    wbDataSelM = 2'b11; imm8M = 16'h0055;
    regWrtM = 1; wrtRegM = 3'd5;
    push(16'h0055, 1, 3'd5);
    cyc();
    sb_cmp("imm");
    #2 rst = 1;
    #1 chk_zero("rst_mid");
    cyc();
    rst = 0;
    idle_in();
    wbDataSelM = 2'b01; aluFinalM = 16'h1234;
    regWrtM = 1; wrtRegM = 3'd3;
    push(16'h1234, 1, 3'd3);
    cyc();
    sb_cmp("alu_after_rst");

    // zero-wait load
    idle_in();
    readEnM = 1; aluOutM = 16'h0040; wbDataSelM = 2'b00;
    memDone = 1; memRdData = 16'hBEEF;
    regWrtM = 1; wrtRegM = 3'd2;
    #1;
    check("zw.rd", memRd, 1);
    check("zw.wr", memWr, 0);
    check("zw.addr", memAddr, 16'h0040);
    check("zw.stall", stallM, 0);
    push(16'hBEEF, 1, 3'd2);
    cyc();
    sb_cmp("zw_load");

    // 3-wait store, X2M inputs change while waiting
    idle_in();
    memWrtM = 1; aluOutM = 16'h0010; wrtDataM = 16'h00AA;
    wbDataSelM = 2'b01; aluFinalM = 16'h7777;
    regWrtM = 0; wrtRegM = 3'd4;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        aluOutM = 16'hFFFF; wrtDataM = 16'h1111; memWrtM = 0;
        aluFinalM = 16'h2222; wrtRegM = 3'd6;
      end
      #1;
      if (stallM) n++;
      check("st.addr", memAddr, 16'h0010);
      check("st.data", memData, 16'h00AA);
      check("st.wr", memWr, 1);
      if (i > 0) check("st.bubble", regWrtW, 0);
      cyc();
    end
    memDone = 1;
    #1;
    check("st.done_stall", stallM, 0);
    check("st.done_wr", memWr, 1);
    check("st.done_addr", memAddr, 16'h0010);
    check("st.stalls", n, 3);
    push(16'h7777, 0, 3'd4);
    cyc();
    sb_cmp("st_commit");

    // back-to-back: next op right after commit
    idle_in();
    wbDataSelM = 2'b10; addPCM = 16'h0C0C;
    regWrtM = 1; wrtRegM = 3'd1;
    #1;
    check("b2b.wr_drop", memWr, 0);
    check("b2b.stall", stallM, 0);
    push(16'h0C0C, 1, 3'd1);
    cyc();
    sb_cmp("b2b_pc");

    // timeout on a load that never completes
    idle_in();
    readEnM = 1; aluOutM = 16'h0020; wbDataSelM = 2'b00;
    regWrtM = 1; wrtRegM = 3'd6;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stallM) break;
      n++;
      cyc();
    end
    check("to.stalls", n, 15);
    check("to.rd_held", memRd, 1);
    idle_in();
    cyc();
    check("to.err", errM, 1);
    check("to.bubble", regWrtW, 0);
    check("to.rd_drop", memRd, 0);
    check("to.idle", stallM, 0);
    wbDataSelM = 2'b01; aluFinalM = 16'hABCD;
    regWrtM = 1; wrtRegM = 3'd7;
    push(16'hABCD, 1, 3'd7);
    cyc();
    sb_cmp("to_alu");
    check("to.sticky", errM, 1);

    // conflict, then reset in WAIT coincident with memDone
    idle_in();
    rst = 1;
    #1 check("cf.err_clr", errM, 0);
    cyc();
    rst = 0;
    memWrtM = 1; readEnM = 1; aluOutM = 16'h0030;
    wrtDataM = 16'h5A5A; regWrtM = 1; wrtRegM = 3'd2;
    wbDataSelM = 2'b01; aluFinalM = 16'h9999;
    #1;
    check("cf.wr", memWr, 1);
    check("cf.rd", memRd, 0);
    cyc();
    check("cf.err", errM, 1);
    check("cf.wait", stallM, 1);
    memDone = 1;
    rst = 1;
    #1;
    check("cf.rst_wr", memWr, 0);
    check("cf.rst_err", errM, 0);
    cyc();
    check("cf.no_commit_rw", regWrtW, 0);
    check("cf.no_commit_wb", wbDataW, 0);
    check("cf.err_after", errM, 0);
    rst = 0;
    idle_in();
    cyc();
    check("cf.idle_stall", stallM, 0);
    check("cf.idle_err", errM, 0);

    check("sb.empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
